// File: rtl/idac_ramp_gen.sv
// idac_ramp_gen: programmable down/up/triangle/hold code generator for an N-bit R2R current DAC
//
// Ports:
//   clk    system clock
//   reset  asynchronous reset, active-low
//   en     run enable; low freezes prescaler, ib and dir
//   mode   00 down-ramp, 01 up-ramp, 10 triangle, 11 hold
//   step   code increment per update
//   lo/hi  inclusive code limits
//   div    update every div+1 enabled cycles
//   ib     registered DAC code
//   wrap   one-cycle pulse with the ib update that ends a ramp period
//   dir    current direction, 1 = up
module idac_ramp_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] ib,
    output logic             wrap,
    output logic             dir
);
    logic [WIDTH-1:0] ib_q, ib_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d, wrap_q, wrap_d, init_q;
    logic [WIDTH-1:0] start;
    logic [WIDTH:0]   up_sum, lo_sum;
    logic             tick, cfg_ok, oor, up_over, dn_under;

    assign start    = (mode == 2'b01) ? lo : hi;
    assign tick     = en & ~init_q & (cnt_q == div);
    assign cfg_ok   = (lo <= hi) & (step != '0);
    assign oor      = (ib_q < lo) | (ib_q > hi);
    // Widened compares: ib+step>hi and ib-step<lo (as ib<lo+step) never wrap.
    assign up_sum   = {1'b0, ib_q} + {1'b0, step};
    assign lo_sum   = {1'b0, lo} + {1'b0, step};
    assign up_over  = up_sum > {1'b0, hi};
    assign dn_under = {1'b0, ib_q} < lo_sum;

    always_comb begin
        ib_d   = ib_q;
        dir_d  = dir_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (init_q) begin
            ib_d  = start;
            dir_d = (mode == 2'b01);
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick && cfg_ok) begin
                if (oor) begin
                    ib_d  = start;
                    dir_d = (mode == 2'b01);
                end else begin
                    case (mode)
                        2'b00: begin
                            ib_d   = dn_under ? hi : ib_q - step;
                            wrap_d = dn_under;
                            dir_d  = 1'b0;
                        end
                        2'b01: begin
                            ib_d   = up_over ? lo : up_sum[WIDTH-1:0];
                            wrap_d = up_over;
                            dir_d  = 1'b1;
                        end
                        2'b10: begin
                            if (dir_q) begin
                                ib_d  = up_over ? hi : up_sum[WIDTH-1:0];
                                dir_d = ~up_over;
                            end else begin
                                ib_d   = dn_under ? lo : ib_q - step;
                                dir_d  = dn_under;
                                wrap_d = dn_under;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ib_q   <= '1;
            dir_q  <= 1'b0;
            wrap_q <= 1'b0;
            cnt_q  <= '0;
            init_q <= 1'b1;
        end else begin
            ib_q   <= ib_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
            cnt_q  <= cnt_d;
            init_q <= 1'b0;
        end
    end

    assign ib   = ib_q;
    assign wrap = wrap_q;
    assign dir  = dir_q;
endmodule

// File: tb/tb_idac_ramp_gen.sv
// tb_idac_ramp_gen: vector table, corner sequences and randomized run against a reference model
module tb_idac_ramp_gen;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] step = 8'd1, lo = 8'd0, hi = 8'd255, div = 8'd0;
    logic [7:0] ib;
    logic       wrap, dir;

    int total = 0, passed = 0;
    int m_ib, m_cnt;
    bit m_dir, m_wrap, m_init;

    typedef struct {
        bit       r;
        bit [1:0] m;
        int       l, h, s, d;
        bit       e;
        int       xi;
        bit       xw, xd;
    } vec_t;
    vec_t v[$];

    idac_ramp_gen #(.WIDTH(8), .DIV_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .step(step),
        .lo(lo), .hi(hi), .div(div), .ib(ib), .wrap(wrap), .dir(dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d want %0d", n, a, e);
    endtask

    task automatic model_rst();
        m_ib = 255; m_cnt = 0; m_dir = 0; m_wrap = 0; m_init = 1;
    endtask

    task automatic model_edge();
        int L, H, S, st, md;
        bit t;
        L = int'(lo); H = int'(hi); S = int'(step); md = int'(mode);
        st = (md == 1) ? L : H;
        m_wrap = 0;
        if (m_init) begin
            m_ib = st; m_dir = (md == 1); m_cnt = 0; m_init = 0;
        end else if (en) begin
            t = (m_cnt == int'(div));
            m_cnt = t ? 0 : (m_cnt + 1) % 256;
            if (t && L <= H && S != 0) begin
                if (m_ib < L || m_ib > H) begin
                    m_ib = st; m_dir = (md == 1);
                end else if (md == 0) begin
                    if (m_ib - S < L) begin m_ib = H; m_wrap = 1; end
                    else m_ib -= S;
                    m_dir = 0;
                end else if (md == 1) begin
                    if (m_ib + S > H) begin m_ib = L; m_wrap = 1; end
                    else m_ib += S;
                    m_dir = 1;
                end else if (md == 2) begin
                    if (m_dir) begin
                        if (m_ib + S > H) begin m_ib = H; m_dir = 0; end
                        else m_ib += S;
                    end else begin
                        if (m_ib - S < L) begin m_ib = L; m_dir = 1; m_wrap = 1; end
                        else m_ib -= S;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_rst();
        #2 reset = 1'b1;
    endtask

    task automatic cfg(input bit [1:0] m, input int l, input int h, input int s, input int d, input bit e);
        mode = m; lo = 8'(l); hi = 8'(h); step = 8'(s); div = 8'(d); en = e;
    endtask

    function automatic vec_t mk(input bit r, input bit [1:0] m, input int l, input int h, input int s,
                                input int d, input bit e, input int xi, input bit xw, input bit xd);
        vec_t x;
        x.r = r; x.m = m; x.l = l; x.h = h; x.s = s; x.d = d; x.e = e;
        x.xi = xi; x.xw = xw; x.xd = xd;
        return x;
    endfunction

    initial begin
        // up-ramp 10..50 step 7
        v.push_back(mk(1, 1, 10, 50, 7, 0, 1, 10, 0, 1));
        v.push_back(mk(0, 1, 10, 50, 7, 0, 1, 17, 0, 1));
        v.push_back(mk(0, 1, 10, 50, 7, 0, 1, 24, 0, 1));
        v.push_back(mk(0, 1, 10, 50, 7, 0, 1, 31, 0, 1));
        v.push_back(mk(0, 1, 10, 50, 7, 0, 1, 38, 0, 1));
        v.push_back(mk(0, 1, 10, 50, 7, 0, 1, 45, 0, 1));
        v.push_back(mk(0, 1, 10, 50, 7, 0, 1, 10, 1, 1));
        v.push_back(mk(0, 1, 10, 50, 7, 0, 1, 17, 0, 1));
        // triangle 0..20 step 6
        v.push_back(mk(1, 2, 0, 20, 6, 0, 1, 20, 0, 0));
        v.push_back(mk(0, 2, 0, 20, 6, 0, 1, 14, 0, 0));
        v.push_back(mk(0, 2, 0, 20, 6, 0, 1, 8, 0, 0));
        v.push_back(mk(0, 2, 0, 20, 6, 0, 1, 2, 0, 0));
        v.push_back(mk(0, 2, 0, 20, 6, 0, 1, 0, 1, 1));
        v.push_back(mk(0, 2, 0, 20, 6, 0, 1, 6, 0, 1));
        v.push_back(mk(0, 2, 0, 20, 6, 0, 1, 12, 0, 1));
        v.push_back(mk(0, 2, 0, 20, 6, 0, 1, 18, 0, 1));
        v.push_back(mk(0, 2, 0, 20, 6, 0, 1, 20, 0, 0));
        v.push_back(mk(0, 2, 0, 20, 6, 0, 1, 14, 0, 0));
        // invalid configs hold, then out-of-range reload
        v.push_back(mk(1, 1, 5, 100, 35, 0, 1, 5, 0, 1));
        v.push_back(mk(0, 1, 5, 100, 35, 0, 1, 40, 0, 1));
        v.push_back(mk(0, 1, 5, 100, 0, 0, 1, 40, 0, 1));
        v.push_back(mk(0, 1, 5, 100, 0, 0, 1, 40, 0, 1));
        v.push_back(mk(0, 1, 60, 50, 1, 0, 1, 40, 0, 1));
        v.push_back(mk(0, 0, 0, 30, 1, 0, 1, 30, 0, 0));
        v.push_back(mk(0, 0, 0, 30, 1, 0, 1, 29, 0, 0));
        // hold mode freezes code
        v.push_back(mk(0, 3, 0, 30, 1, 0, 1, 29, 0, 0));
        v.push_back(mk(0, 3, 0, 30, 1, 0, 1, 29, 0, 0));

        model_rst();
        // reset state, then full-range down-ramp with wrap
        cfg(0, 0, 255, 1, 0, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ib", ib, 255); chk("rst_wrap", wrap, 0); chk("rst_dir", dir, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        chk("t1_init_ib", ib, 255);
        for (int k = 1; k <= 255; k++) begin
            cyc();
            chk("t1_ib", ib, 255 - k);
            chk("t1_wrap", wrap, 0);
        end
        cyc();
        chk("t1_wrap_ib", ib, 255); chk("t1_wrap_pulse", wrap, 1);
        cyc();
        chk("t1_after_ib", ib, 254); chk("t1_wrap_clear", wrap, 0);

        foreach (v[i]) begin
            if (v[i].r) do_reset();
            cfg(v[i].m, v[i].l, v[i].h, v[i].s, v[i].d, v[i].e);
            cyc();
            chk($sformatf("vec%0d_ib", i), ib, v[i].xi);
            chk($sformatf("vec%0d_wrap", i), wrap, v[i].xw);
            chk($sformatf("vec%0d_dir", i), dir, v[i].xd);
        end

        // prescaler div=3 with enable pause mid-count
        cfg(0, 0, 100, 1, 3, 1);
        do_reset();
        cyc();
        chk("t4_init", ib, 100);
        for (int k = 0; k < 3; k++) begin cyc(); chk("t4_wait", ib, 100); end
        cyc(); chk("t4_tick1", ib, 99);
        cyc(); cyc();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(); chk("t4_frozen", ib, 99); chk("t4_frozen_wrap", wrap, 0);
        end
        en = 1'b1;
        cyc(); chk("t4_resume", ib, 99);
        cyc(); chk("t4_tick2", ib, 98);

        // async reset mid-cycle during up-ramp
        cfg(1, 10, 50, 7, 0, 1);
        do_reset();
        cyc(); cyc(); cyc();
        chk("t5_run", ib, 24);
        #3 reset = 1'b0;
        model_rst();
        #1;
        chk("t5_async_ib", ib, 255); chk("t5_async_wrap", wrap, 0); chk("t5_async_dir", dir, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        chk("t5_init_ib", ib, 10); chk("t5_init_dir", dir, 1);

        // randomized run against the model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                lo = 8'($urandom_range(0, 200));
                hi = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(int'(lo), 255));
                step = 8'($urandom_range(0, 40));
                div = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            cyc();
            chk("rnd_ib", ib, m_ib);
            chk("rnd_wrap", wrap, m_wrap);
            chk("rnd_dir", dir, m_dir);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/idac_ramp_gen.md
Name: idac_ramp_gen

Overview:
Parametrised code-pattern generator driving the N-bit R2R current DAC input bus `ib`. It replaces the fixed 8-bit free-running down-counter stimulus. Four modes are selectable at run time: down-ramp, up-ramp, triangle and hold. Programmable limits, step size and update-rate prescaler allow characterisation sweeps without reflashing. It sits between the digital control/test logic and the DAC.

Parameters:
WIDTH, 8, DAC code width (ib, step, lo, hi)
DIV_W, 8, prescaler width

Ports:
clk  input  1  system clock (10 MHz nominal)
reset  input  1  asynchronous reset, active-low
en  input  1  run enable; low freezes all update state
mode  input  2  00 down-ramp, 01 up-ramp, 10 triangle, 11 hold
step  input  WIDTH  code increment per update
lo  input  WIDTH  lower code limit (inclusive)
hi  input  WIDTH  upper code limit (inclusive)
div  input  DIV_W  update every div+1 enabled cycles
ib  output  WIDTH  code to the R2R DAC (registered)
wrap  output  1  one-cycle pulse at end of a ramp period
dir  output  1  current direction, 1 = up

Behaviour:
- Reset asserted (reset=0), asynchronous:
  - ib = all-ones (2^WIDTH-1), wrap = 0, dir = 0.
  - Prescaler count cnt = 0; internal init flag = 1.
- Init cycle: the first rising clk edge after reset deasserts performs init. This is independent of en.
  - ib loads the start value: hi for modes 00/10/11, lo for mode 01.
  - dir = 1 for mode 01, else 0.
  - init clears; cnt = 0; wrap = 0.
- Prescaler: runs only when en=1 and init=0.
  - If cnt==div: cnt<=0 and tick=1 this cycle.
  - Otherwise cnt<=cnt+1.
  - div=0 gives a tick every enabled cycle.
  - en=0 holds cnt, ib, dir; wrap = 0.
- Arithmetic: all compares use WIDTH+1 bits, so there is no silent wrap-around.
- On tick, where start = start value of current mode:
  - Invalid config (lo>hi or step==0): ib, dir hold; wrap=0.
  - Out of range (ib<lo or ib>hi, e.g. limits changed): ib<=start, dir per mode rule above; wrap=0. This rule takes precedence over the mode rules below.
  - 00 down: if ib-step<lo then ib<=hi, wrap=1; else ib<=ib-step. dir=0.
  - 01 up: if ib+step>hi then ib<=lo, wrap=1; else ib<=ib+step. dir=1.
  - 10 triangle, dir=1: if ib+step>hi then ib<=hi, dir<=0; else ib<=ib+step.
  - 10 triangle, dir=0: if ib-step<lo then ib<=lo, dir<=1, wrap=1; else ib<=ib-step.
  - 11 hold: ib holds, dir holds, wrap=0.
- Mode change: mode is sampled at each tick only. ib is not reloaded unless out of range. dir is forced to the mode's value on the first tick in 00/01; triangle continues from the current dir.
- wrap: registered; high exactly one cycle, coincident with the ib update that caused it; 0 on non-tick cycles.
- Latency: ib changes on the clk edge at which tick is asserted, i.e. 1 cycle after the cnt==div condition is evaluated.
- Reset mid-operation: immediate return to reset values, then a new init cycle.

Test Plan:
1. WIDTH=8, mode=00, lo=0, hi=255, step=1, div=0, en=1, release reset -> ib=255 through the init edge, then 254, 253 ... 0 on the 255th tick; next tick ib=255 with wrap=1 for exactly one cycle.
2. mode=01, lo=10, hi=50, step=7, div=0 -> ib sequence 10, 17, 24, 31, 38, 45, then 10 with wrap=1, dir=1 throughout.
3. mode=10, lo=0, hi=20, step=6 -> sequence 20, 14, 8, 2, then 0 (dir->1, wrap=1), then 6, 12, 18, then 20 (dir->0, wrap=0), then 14.
4. div=3, mode=00, hi=100, step=1 -> ib steps every 4 cycles: 100, 99, 98. Drop en for 5 cycles mid-count -> ib and cnt frozen; the remaining count completes after en returns.
5. Assert reset asynchronously mid-cycle during mode=01 run -> ib=255, wrap=0, dir=0 without waiting for clk. After release, the init edge loads lo.
6. With ib=40, set step=0 -> ib holds, no wrap. Then set lo=60, hi=50 -> ib holds. Then set lo=0, hi=30 (ib out of range), mode=00 -> next tick ib=30, wrap=0.
